// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press/release/repeat events plus long-press and busy levels.
// Optional press counter and clear input: define BUTTON_EVT_PRESS_COUNT_EN.
module button_event_gen #(
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buttonState,
`ifdef BUTTON_EVT_PRESS_COUNT_EN
  input  logic       countClear,
  output logic [7:0] pressCount,
`endif
  output logic       pressPulse,
  output logic       releasePulse,
  output logic       repeatPulse,
  output logic       longPress,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REPEATING
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             press_nx, release_nx, repeat_nx, long_nx, busy_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      repeatPulse  <= 1'b0;
      longPress    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      pressPulse   <= press_nx;
      releasePulse <= release_nx;
      repeatPulse  <= repeat_nx;
      longPress    <= long_nx;
      busy         <= busy_nx;
    end
  end

  // Release is tested before the threshold so a release on the threshold edge wins.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    repeat_nx  = 1'b0;
    long_nx    = longPress;
    case (state)
      IDLE: begin
        long_nx = 1'b0;
        if (buttonState) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          press_nx = 1'b1;
        end
      end
      PRESSED: begin
        if (!buttonState) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
          long_nx    = 1'b0;
        end else if (cnt == HOLD_LAST) begin
          state_nx  = REPEATING;
          cnt_nx    = '0;
          long_nx   = 1'b1;
          repeat_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      REPEATING: begin
        if (!buttonState) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
          long_nx    = 1'b0;
        end else if (cnt == REPEAT_LAST) begin
          cnt_nx    = '0;
          repeat_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        long_nx  = 1'b0;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

`ifdef BUTTON_EVT_PRESS_COUNT_EN
  logic [7:0] count_nx;

  always_comb begin
    count_nx = pressCount;
    if (countClear) begin
      count_nx = '0;
    end else if (press_nx && (pressCount != 8'hFF)) begin
      count_nx = pressCount + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressCount <= '0;
    end else begin
      pressCount <= count_nx;
    end
  end
`endif

endmodule
